// File: rtl/seq_det_pkg.sv
// Shared types and 7-segment codes for the 0,1,0*,1 sequence detector.
// Segment codes are active-low, bit0=a through bit6=g.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_01,
        S_01Z
    } state_e;

    localparam logic [6:0] SEG_D0    = 7'h40;
    localparam logic [6:0] SEG_D1    = 7'h79;
    localparam logic [6:0] SEG_D2    = 7'h24;
    localparam logic [6:0] SEG_D3    = 7'h30;
    localparam logic [6:0] SEG_D4    = 7'h19;
    localparam logic [6:0] SEG_D5    = 7'h12;
    localparam logic [6:0] SEG_D6    = 7'h02;
    localparam logic [6:0] SEG_D7    = 7'h78;
    localparam logic [6:0] SEG_D8    = 7'h00;
    localparam logic [6:0] SEG_D9    = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern.
// Codes above 9 show a blank digit.
module seg7_decoder
    import seq_det_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sequence_detector.sv
// Mealy detector for 0,1,0*,1 with a two-digit BCD hit counter on 7-seg.
// Define SEQDET_SATURATE_EN to make the counter stick at COUNT_MAX.
module sequence_detector
    import seq_det_pkg::*;
#(
    parameter int COUNT_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sig_to_test,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic       z
);

    localparam logic [3:0] MAX_ONES = 4'(COUNT_MAX % 10);
    localparam logic [3:0] MAX_TENS = 4'(COUNT_MAX / 10);

    state_e     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                S_IDLE:  state_d = sig_to_test ? S_IDLE : S_ZERO;
                S_ZERO:  state_d = sig_to_test ? S_01   : S_ZERO;
                S_01:    state_d = sig_to_test ? S_IDLE : S_01Z;
                S_01Z:   state_d = sig_to_test ? S_01   : S_01Z;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        z = ena & ~rst & sig_to_test
            & ((state_q == S_01) | (state_q == S_01Z));
    end

    assign at_max = (ones_q == MAX_ONES) && (tens_q == MAX_TENS);

    // z already folds in ena and rst, so it alone gates the count
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (z) begin
            if (at_max) begin
`ifdef SEQDET_SATURATE_EN
                ones_d = ones_q;
                tens_d = tens_q;
`else
                ones_d = 4'd0;
                tens_d = 4'd0;
`endif
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    seg7_decoder u_seg_ones (
        .digit (ones_q),
        .seg   (disp0)
    );

    seg7_decoder u_seg_tens (
        .digit (tens_q),
        .seg   (disp1)
    );

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector: directed scenarios plus random stream
// checked against a history-scanning reference model.
module tb_sequence_detector;

    localparam int CMAX = 99;
`ifdef SEQDET_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       sig_to_test = 1'b0;
    logic [6:0] disp0;
    logic [6:0] disp1;
    logic       z;

    int n_checks = 0;
    int n_pass   = 0;

    bit         hist[$];
    int         cnt = 0;
    logic       zobs;
    logic [23:0] zmask;

    always #5 clk = ~clk;

    sequence_detector #(.COUNT_MAX(CMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sig_to_test (sig_to_test),
        .disp0       (disp0),
        .disp1       (disp1),
        .z           (z)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Does the stream seen so far plus bit b end in 0 1 0* 1 ?
    function automatic bit ref_hit(input bit b);
        int i;
        if (!b) return 1'b0;
        i = hist.size() - 1;
        while (i >= 0 && hist[i] == 1'b0) i--;
        if (i < 1) return 1'b0;
        return hist[i - 1] == 1'b0;
    endfunction

    task automatic step(input bit r, input bit e, input bit b,
                        input string tag);
        bit ez;
        @(negedge clk);
        rst = r;
        ena = e;
        sig_to_test = b;
        #1;
        ez = !r && e && ref_hit(b);
        zobs = z;
        zmask = {zmask[22:0], z};
        chk({tag, ".z"}, 32'(z), 32'(ez));
        @(posedge clk);
        if (r) begin
            hist.delete();
            cnt = 0;
        end else if (e) begin
            if (ez) cnt = (cnt == CMAX) ? (SAT ? CMAX : 0) : cnt + 1;
            hist.push_back(b);
        end
        #1;
        chk({tag, ".d0"}, 32'(disp0), 32'(seg_of(cnt % 10)));
        chk({tag, ".d1"}, 32'(disp1), 32'(seg_of(cnt / 10)));
    endtask

    task automatic run_bits(input logic [31:0] bits, input int n,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], tag);
    endtask

    initial begin
        logic [31:0] s27;
        bit r, e, b;

        // reset with ena low must still clear
        step(1'b1, 1'b0, 1'b0, "rst");
        chk("rst.d0c", 32'(disp0), 32'h40);
        chk("rst.d1c", 32'(disp1), 32'h40);
        step(1'b0, 1'b1, 1'b1, "r26");
        chk("r26.z0", 32'(zobs), 32'h0);

        step(1'b1, 1'b0, 1'b0, "rst");
        zmask = '0;
        s27 = 32'b000100110001011101010011;
        run_bits(s27, 24, "r27");
        chk("r27.zmask", 32'(zmask), 32'b000000110000011000010011);
        chk("r27.d0c", 32'(disp0), 32'h78);
        chk("r27.d1c", 32'(disp1), 32'h40);

        step(1'b1, 1'b0, 1'b0, "rst");
        zmask = '0;
        run_bits(32'b01101001, 8, "r28");
        chk("r28.zmask", 32'(zmask[7:0]), 32'b00100001);
        chk("r28.d0c", 32'(disp0), 32'h24);

        step(1'b1, 1'b0, 1'b0, "rst");
        run_bits(32'b01, 2, "r29");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, "r29h");
            chk("r29.hold_z", 32'(zobs), 32'h0);
        end
        step(1'b0, 1'b1, 1'b1, "r29r");
        chk("r29.resume_z", 32'(zobs), 32'h1);
        chk("r29.d0c", 32'(disp0), 32'h79);

        step(1'b1, 1'b0, 1'b0, "rst");
        for (int i = 0; i < 99; i++) run_bits(32'b011, 3, "r30");
        chk("r30.99.d0", 32'(disp0), 32'h10);
        chk("r30.99.d1", 32'(disp1), 32'h10);
        run_bits(32'b011, 3, "r30");
        chk("r30.100.d0", 32'(disp0), SAT ? 32'h10 : 32'h40);
        chk("r30.100.d1", 32'(disp1), SAT ? 32'h10 : 32'h40);

        run_bits(32'b010, 3, "r31");
        step(1'b1, 1'b1, 1'b1, "r31r");
        step(1'b0, 1'b1, 1'b1, "r31");
        chk("r31.z", 32'(zobs), 32'h0);
        step(1'b0, 1'b1, 1'b1, "r31i");
        chk("r31.idle_z", 32'(zobs), 32'h0);
        chk("r31.d0c", 32'(disp0), 32'h40);
        chk("r31.d1c", 32'(disp1), 32'h40);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 9) != 0);
            b = 1'($urandom_range(0, 1));
            step(r, e, b, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
